// File: rtl/framebuffer_writer_if.sv
// Byte-stream input and pixel write port of framebuffer_writer.
// clear_req/clear_color exist only when FBW_CLEAR_EN is defined.
interface framebuffer_writer_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              frame_start;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [23:0]       wr_data;
  logic              frame_done;
`ifdef FBW_CLEAR_EN
  logic              clear_req;
  logic [23:0]       clear_color;

  modport master (
    output in_valid, in_data, frame_start, clear_req, clear_color,
    input  in_ready, wr_en, wr_addr, wr_data, frame_done
  );

  modport slave (
    input  in_valid, in_data, frame_start, clear_req, clear_color,
    output in_ready, wr_en, wr_addr, wr_data, frame_done
  );
`else
  modport master (
    output in_valid, in_data, frame_start,
    input  in_ready, wr_en, wr_addr, wr_data, frame_done
  );

  modport slave (
    input  in_valid, in_data, frame_start,
    output in_ready, wr_en, wr_addr, wr_data, frame_done
  );
`endif
endinterface

// File: rtl/framebuffer_writer.sv
// Assembles R,G,B byte triples into 24-bit pixels and writes them in raster order.
// Optional fill sweep (clear_req/clear_color, CLEAR state) enabled by FBW_CLEAR_EN.
module framebuffer_writer #(
  parameter int unsigned IMG_WIDTH  = 200,
  parameter int unsigned IMG_HEIGHT = 200,
  parameter int unsigned ADDR_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  framebuffer_writer_if.slave bus
);

  localparam int unsigned X_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int unsigned Y_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [X_W-1:0] X_LAST = X_W'(IMG_WIDTH - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {
    RX_R  = 2'd0,
    RX_G  = 2'd1,
`ifdef FBW_CLEAR_EN
    RX_B  = 2'd2,
    CLEAR = 2'd3
`else
    RX_B  = 2'd2
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        r_q, r_d;
  logic [7:0]        g_q, g_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [ADDR_W-1:0] pix_q, pix_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [23:0]       wr_data_q, wr_data_d;
  logic              frame_done_q, frame_done_d;

  logic              in_ready_c;
  logic              xfer_c;
  logic              last_c;
  logic              adv_c;

`ifdef FBW_CLEAR_EN
  assign in_ready_c = !rst && (state_q != CLEAR);
`else
  assign in_ready_c = !rst;
`endif
  assign xfer_c = bus.in_valid && in_ready_c;
  assign last_c = (x_q == X_LAST) && (y_q == Y_LAST);

  // Next-state, pixel assembly and write-port drive.
  always_comb begin
    state_d      = state_q;
    r_d          = r_q;
    g_d          = g_q;
    x_d          = x_q;
    y_d          = y_q;
    pix_d        = pix_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    adv_c        = 1'b0;

`ifdef FBW_CLEAR_EN
    if (state_q == CLEAR) begin
      wr_en_d      = 1'b1;
      wr_addr_d    = pix_q;
      wr_data_d    = bus.clear_color;
      frame_done_d = last_c;
      adv_c        = 1'b1;
      if (last_c) begin
        state_d = RX_R;
      end
    end else if (bus.clear_req) begin
      state_d = CLEAR;
      r_d     = '0;
      g_d     = '0;
      x_d     = '0;
      y_d     = '0;
      pix_d   = '0;
    end else
`endif
    if (bus.frame_start) begin
      // A byte arriving with frame_start is the R byte of the new frame.
      r_d     = xfer_c ? bus.in_data : 8'h00;
      g_d     = '0;
      x_d     = '0;
      y_d     = '0;
      pix_d   = '0;
      state_d = xfer_c ? RX_G : RX_R;
    end else if (xfer_c) begin
      case (state_q)
        RX_R: begin
          r_d     = bus.in_data;
          state_d = RX_G;
        end
        RX_G: begin
          g_d     = bus.in_data;
          state_d = RX_B;
        end
        RX_B: begin
          wr_en_d      = 1'b1;
          wr_addr_d    = pix_q;
          wr_data_d    = {r_q, g_q, bus.in_data};
          frame_done_d = last_c;
          adv_c        = 1'b1;
          state_d      = RX_R;
        end
        default: state_d = RX_R;
      endcase
    end

    // Raster advance; pix tracks y*IMG_WIDTH+x incrementally.
    if (adv_c) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        if (y_q == Y_LAST) begin
          y_d   = '0;
          pix_d = '0;
        end else begin
          y_d   = y_q + Y_W'(1);
          pix_d = pix_q + ADDR_W'(1);
        end
      end else begin
        x_d   = x_q + X_W'(1);
        pix_d = pix_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RX_R;
      r_q          <= '0;
      g_q          <= '0;
      x_q          <= '0;
      y_q          <= '0;
      pix_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      r_q          <= r_d;
      g_q          <= g_d;
      x_q          <= x_d;
      y_q          <= y_d;
      pix_q        <= pix_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.frame_done = frame_done_q;

endmodule
